// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load formatting, writeback select and ID-stage bypass.
// Optional retired-instruction counter enabled by defining WB_INSTRET_EN.
module wb_stage #(
   parameter int unsigned XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            m_valid,
   input  logic [31:0]     m_pc,
   input  logic [4:0]      m_rd,
   input  logic            m_reg_wen,
   input  logic [1:0]      m_wb_sel,
   input  logic [2:0]      m_funct3,
   input  logic [XLEN-1:0] m_alu_res,
   input  logic [XLEN-1:0] m_mem_rdata,
   input  logic [XLEN-1:0] m_imm,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [XLEN-1:0] id_rs1_rf,
   input  logic [XLEN-1:0] id_rs2_rf,
   output logic [XLEN-1:0] id_rs1_val,
   output logic [XLEN-1:0] id_rs2_val,
   output logic            rf_wen,
   output logic [4:0]      rf_rd,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_valid,
   output logic [31:0]     wb_pc,
   output logic [63:0]     instret
);

   localparam logic [1:0] SEL_ALU  = 2'b00;
   localparam logic [1:0] SEL_LOAD = 2'b01;
   localparam logic [1:0] SEL_PC4  = 2'b10;

   logic            valid_q,   valid_d;
   logic [31:0]     pc_q,      pc_d;
   logic [4:0]      rd_q,      rd_d;
   logic            reg_wen_q, reg_wen_d;
   logic [1:0]      wb_sel_q,  wb_sel_d;
   logic [2:0]      funct3_q,  funct3_d;
   logic [XLEN-1:0] alu_res_q, alu_res_d;
   logic [XLEN-1:0] rdata_q,   rdata_d;
   logic [XLEN-1:0] imm_q,     imm_d;

   // Flush only clears the valid bit; the payload is left as-is.
   always_comb begin
      valid_d   = valid_q;
      pc_d      = pc_q;
      rd_d      = rd_q;
      reg_wen_d = reg_wen_q;
      wb_sel_d  = wb_sel_q;
      funct3_d  = funct3_q;
      alu_res_d = alu_res_q;
      rdata_d   = rdata_q;
      imm_d     = imm_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (!stall) begin
         valid_d   = m_valid;
         pc_d      = m_pc;
         rd_d      = m_rd;
         reg_wen_d = m_reg_wen;
         wb_sel_d  = m_wb_sel;
         funct3_d  = m_funct3;
         alu_res_d = m_alu_res;
         rdata_d   = m_mem_rdata;
         imm_d     = m_imm;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         pc_q      <= RESET_PC;
         rd_q      <= '0;
         reg_wen_q <= 1'b0;
         wb_sel_q  <= '0;
         funct3_q  <= '0;
         alu_res_q <= '0;
         rdata_q   <= '0;
         imm_q     <= '0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         rd_q      <= rd_d;
         reg_wen_q <= reg_wen_d;
         wb_sel_q  <= wb_sel_d;
         funct3_q  <= funct3_d;
         alu_res_q <= alu_res_d;
         rdata_q   <= rdata_d;
         imm_q     <= imm_d;
      end
   end

   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [XLEN-1:0] ld_data;

   // Halfword select uses only off[1]; misaligned halfwords are not trapped.
   always_comb begin
      ld_byte = rdata_q[7:0];
      case (alu_res_q[1:0])
         2'd1:    ld_byte = rdata_q[15:8];
         2'd2:    ld_byte = rdata_q[23:16];
         2'd3:    ld_byte = rdata_q[31:24];
         default: ld_byte = rdata_q[7:0];
      endcase
      ld_half = alu_res_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (funct3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = rdata_q;
      endcase
   end

   always_comb begin
      case (wb_sel_q)
         SEL_ALU:  rf_wdata = alu_res_q;
         SEL_LOAD: rf_wdata = ld_data;
         SEL_PC4:  rf_wdata = pc_q + 32'd4;
         default:  rf_wdata = imm_q;
      endcase
   end

   assign rf_wen   = valid_q & reg_wen_q & (rd_q != 5'd0);
   assign rf_rd    = rd_q;
   assign wb_valid = valid_q;
   assign wb_pc    = pc_q;

   // The register file commits at the next edge, so forward the pending write.
   assign id_rs1_val = (rf_wen && (rf_rd == id_rs1)) ? rf_wdata : id_rs1_rf;
   assign id_rs2_val = (rf_wen && (rf_rd == id_rs2)) ? rf_wdata : id_rs2_rf;

`ifdef WB_INSTRET_EN
   logic [63:0] instret_q, instret_d;

   always_comb begin
      instret_d = instret_q;
      if (valid_q && !stall && !flush) instret_d = instret_q + 64'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) instret_q <= 64'd0;
      else     instret_q <= instret_d;
   end

   assign instret = instret_q;
`else
   assign instret = 64'd0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage.
module tb_wb_stage;

   localparam logic [31:0] RST_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst, stall, flush;
   logic        m_valid, m_reg_wen;
   logic [31:0] m_pc, m_alu_res, m_mem_rdata, m_imm;
   logic [4:0]  m_rd, id_rs1, id_rs2;
   logic [1:0]  m_wb_sel;
   logic [2:0]  m_funct3;
   logic [31:0] id_rs1_rf, id_rs2_rf, id_rs1_val, id_rs2_val;
   logic        rf_wen, wb_valid;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wdata, wb_pc;
   logic [63:0] instret;

   int checks = 0;
   int errors = 0;

   wb_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_pc(m_pc), .m_rd(m_rd), .m_reg_wen(m_reg_wen),
      .m_wb_sel(m_wb_sel), .m_funct3(m_funct3), .m_alu_res(m_alu_res),
      .m_mem_rdata(m_mem_rdata), .m_imm(m_imm),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_rf(id_rs1_rf), .id_rs2_rf(id_rs2_rf),
      .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
      .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .instret(instret)
   );

   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [4:0] rd, input logic wen,
                        input logic [1:0] sel, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] imm, input logic [31:0] pc);
      m_valid = v; m_rd = rd; m_reg_wen = wen; m_wb_sel = sel; m_funct3 = f3;
      m_alu_res = alu; m_mem_rdata = rdata; m_imm = imm; m_pc = pc;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 5'd5, 1'b1, 2'b00, 3'b010, 32'h0000_0055, 32'h0, 32'h0, 32'h0000_0200);
      step();
      checks++;
      if (rf_wen !== 1'b1) begin errors++; $display("FAIL reset_pre_wen got %b want 1", rf_wen); end
      drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_async_wen got %b want 0", rf_wen); end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if ({wb_valid, rf_wen, rf_rd, rf_wdata} !== 39'd0)
         begin errors++; $display("FAIL reset_outputs got v=%b wen=%b rd=%0d wd=%h want zeros", wb_valid, rf_wen, rf_rd, rf_wdata); end
      checks++;
      if (wb_pc !== RST_PC) begin errors++; $display("FAIL reset_pc got %h want %h", wb_pc, RST_PC); end
      checks++;
      if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
   endtask

   task automatic test_alu();
      drive(1'b1, 5'd7, 1'b1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 32'h0000_0300);
      step();
      checks++;
      if (rf_wen !== 1'b1 || rf_rd !== 5'd7 || rf_wdata !== 32'h1234_5678)
         begin errors++; $display("FAIL alu_write got wen=%b rd=%0d wd=%h want 1/7/12345678", rf_wen, rf_rd, rf_wdata); end
      drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 32'h1234_5678, 32'h0, 32'h0, 32'h0000_0304);
      step();
      checks++;
      if (rf_wen !== 1'b0) begin errors++; $display("FAIL alu_x0_wen got %b want 0", rf_wen); end
      drive(1'b0, 5'd9, 1'b1, 2'b00, 3'b000, 32'h1, 32'h0, 32'h0, 32'h0);
      step();
      checks++;
      if (rf_wen !== 1'b0 || wb_valid !== 1'b0)
         begin errors++; $display("FAIL alu_invalid got wen=%b v=%b want 0/0", rf_wen, wb_valid); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3  [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011};
      logic [1:0]  off [7] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd2, 2'd3, 2'd1};
      logic [31:0] exp [7] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01,
                               32'h80FF_7F01, 32'hFFFF_80FF, 32'h80FF_7F01};
      for (int i = 0; i < 7; i++) begin
         drive(1'b1, 5'd10, 1'b1, 2'b01, f3[i], {30'h0000_0100, off[i]}, 32'h80FF_7F01, 32'h0, 32'h0000_0400);
         step();
         checks++;
         if (rf_wdata !== exp[i])
            begin errors++; $display("FAIL load_%0d f3=%b off=%0d got %h want %h", i, f3[i], off[i], rf_wdata, exp[i]); end
      end
   endtask

   task automatic test_jal_lui();
      drive(1'b1, 5'd1, 1'b1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFC);
      step();
      checks++;
      if (rf_wdata !== 32'h0) begin errors++; $display("FAIL jal_wrap got %h want 0", rf_wdata); end
      drive(1'b1, 5'd2, 1'b1, 2'b11, 3'b000, 32'h0, 32'h0, 32'hABCD_E000, 32'h0000_0500);
      step();
      checks++;
      if (rf_wdata !== 32'hABCD_E000) begin errors++; $display("FAIL lui got %h want abcde000", rf_wdata); end
   endtask

   task automatic test_bypass();
      drive(1'b1, 5'd3, 1'b1, 2'b00, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0000_0600);
      step();
      id_rs1 = 5'd3; id_rs2 = 5'd4; id_rs1_rf = 32'h0; id_rs2_rf = 32'h5;
      #1;
      checks++;
      if (id_rs1_val !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_rs1 got %h want deadbeef", id_rs1_val); end
      checks++;
      if (id_rs2_val !== 32'h5) begin errors++; $display("FAIL bypass_rs2 got %h want 5", id_rs2_val); end
      drive(1'b1, 5'd0, 1'b1, 2'b00, 3'b000, 32'hCAFE_0000, 32'h0, 32'h0, 32'h0000_0604);
      step();
      id_rs1 = 5'd0; id_rs1_rf = 32'h0000_1111; id_rs2 = 5'd0; id_rs2_rf = 32'h0000_2222;
      #1;
      checks++;
      if (id_rs1_val !== 32'h0000_1111 || id_rs2_val !== 32'h0000_2222)
         begin errors++; $display("FAIL bypass_x0 got %h/%h want 00001111/00002222", id_rs1_val, id_rs2_val); end
   endtask

   task automatic test_stall_flush();
      logic [63:0] exp3;
`ifdef WB_INSTRET_EN
      exp3 = 64'd3;
`else
      exp3 = 64'd0;
`endif
      rst = 1'b1; #1; rst = 1'b0;
      drive(1'b1, 5'd11, 1'b1, 2'b00, 3'b000, 32'hAAAA_0001, 32'h0, 32'h0, 32'h0000_0700);
      step();
      stall = 1'b1;
      drive(1'b1, 5'd12, 1'b1, 2'b00, 3'b000, 32'hBBBB_0002, 32'h0, 32'h0, 32'h0000_0704);
      for (int c = 0; c < 2; c++) begin
         step();
         checks++;
         if (rf_wdata !== 32'hAAAA_0001 || rf_rd !== 5'd11 || wb_pc !== 32'h0000_0700 || wb_valid !== 1'b1)
            begin errors++; $display("FAIL stall_hold_%0d got wd=%h rd=%0d pc=%h v=%b want aaaa0001/11/00000700/1", c, rf_wdata, rf_rd, wb_pc, wb_valid); end
      end
      stall = 1'b0;
      step();
      checks++;
      if (rf_wdata !== 32'hBBBB_0002) begin errors++; $display("FAIL stall_release got %h want bbbb0002", rf_wdata); end
      drive(1'b1, 5'd13, 1'b1, 2'b00, 3'b000, 32'hCCCC_0003, 32'h0, 32'h0, 32'h0000_0708);
      step();
      drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      step();
      checks++;
      if (instret !== exp3) begin errors++; $display("FAIL instret_count got %0d want %0d", instret, exp3); end
      drive(1'b1, 5'd14, 1'b1, 2'b00, 3'b000, 32'hDDDD_0004, 32'h0, 32'h0, 32'h0000_070C);
      step();
      stall = 1'b1; flush = 1'b1;
      drive(1'b1, 5'd15, 1'b1, 2'b00, 3'b000, 32'hEEEE_0005, 32'h0, 32'h0, 32'h0000_0710);
      step();
      stall = 1'b0; flush = 1'b0;
      checks++;
      if (wb_valid !== 1'b0 || rf_wen !== 1'b0)
         begin errors++; $display("FAIL flush_stall got v=%b wen=%b want 0/0", wb_valid, rf_wen); end
      checks++;
      if (instret !== exp3) begin errors++; $display("FAIL flush_instret got %0d want %0d", instret, exp3); end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_rf = 32'h0; id_rs2_rf = 32'h0;
      drive(1'b0, 5'd0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0);
      #1;
      checks++;
      if (wb_valid !== 1'b0 || wb_pc !== RST_PC || rf_wen !== 1'b0 || rf_wdata !== 32'h0)
         begin errors++; $display("FAIL init_reset got v=%b pc=%h wen=%b wd=%h", wb_valid, wb_pc, rf_wen, rf_wdata); end
      step();
      rst = 1'b0;
      test_reset();
      test_alu();
      test_loads();
      test_jal_lui();
      test_bypass();
      test_stall_flush();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
